mem_stage_hs: RTL

- Parametrised successor of the MEM pipeline stage.
- Sits between EX and WB. Accepts a handshake-based data bus: the request is issued in EX, and MEM waits for `data_ok`.
- Supports 32/64-bit datapaths with byte/half/word/double load alignment and sign/zero extension.
- Provides a response holding buffer and cancellation of in-flight responses after a WB flush.

---
 rtl/mem_stage_hs.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mem_stage_hs.sv
// MEM pipeline stage with handshake data bus: waits for data_ok, buffers a response
// when WB stalls, formats loads, and discards responses orphaned by a WB flush.
module mem_stage_hs #(
  parameter int DATA_W   = 32,
  parameter int MAX_OUTS = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              es2ms_valid,
  output logic              ms_allowin,
  input  logic [DATA_W-1:0] es_pc,
  input  logic [DATA_W-1:0] es_alu_result,
  input  logic [6:0]        es_load_op,
  input  logic              es_mem_req,
  input  logic [4:0]        es_dest,
  input  logic              es_gr_we,
  input  logic              es_ex,
  input  logic              data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  input  logic              ws_allowin,
  input  logic              wb_flush,
  output logic              ms2ws_valid,
  output logic [DATA_W-1:0] ms_pc,
  output logic [4:0]        ms_dest,
  output logic              ms_gr_we,
  output logic [DATA_W-1:0] ms_result,
  output logic              ms_ex_out,
  output logic              fwd_we,
  output logic [4:0]        fwd_dest,
  output logic              fwd_ready
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int CNT_W = $clog2(MAX_OUTS + 1);

  logic              r_ms_valid;
  logic              r_waiting;
  logic              r_buf_valid;
  logic [CNT_W-1:0]  r_cancel_cnt;
  logic [DATA_W-1:0] r_rbuf;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_alu_result;
  logic [6:0]        r_load_op;
  logic [4:0]        r_dest;
  logic              r_gr_we;
  logic              r_ex;

  logic              w_cancel_active;
  logic              w_drop;
  logic              w_ok_live;
  logic              w_ready_go;
  logic              w_allowin;
  logic              w_out_valid;
  logic              w_leave;
  logic              w_capture;
  logic              w_to_buf;
  logic [CNT_W:0]    w_cnt_inc;
  logic [CNT_W:0]    w_cnt_sum;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [DATA_W-1:0] w_rd;
  logic [DATA_W-1:0] w_shifted;
  logic signed [7:0]  w_sb;
  logic signed [15:0] w_sh;
  logic signed [31:0] w_sw;
  logic [DATA_W-1:0] w_ld_data;

  // A data_ok seen while cancellations are pending belongs to a flushed request.
  assign w_cancel_active = (r_cancel_cnt != '0);
  assign w_drop          = data_ok & w_cancel_active;
  assign w_ok_live       = data_ok & ~w_cancel_active;

  assign w_ready_go  = ~r_waiting | r_buf_valid | w_ok_live;
  assign w_allowin   = ~r_ms_valid | (w_ready_go & ws_allowin);
  assign w_out_valid = r_ms_valid & w_ready_go;
  assign w_leave     = w_out_valid & ws_allowin;
  assign w_capture   = es2ms_valid & w_allowin & ~wb_flush;
  assign w_to_buf    = r_waiting & ~r_buf_valid & w_ok_live & ~ws_allowin;

  // Flush orphans the response MEM is waiting for and any request EX already issued.
  assign w_cnt_inc = wb_flush ?
                     ((CNT_W+1)'(r_waiting & ~r_buf_valid & ~w_ok_live) +
                      (CNT_W+1)'(es2ms_valid & es_mem_req)) : '0;
  assign w_cnt_sum  = {1'b0, r_cancel_cnt} + w_cnt_inc - (CNT_W+1)'(w_drop);
  assign w_cnt_next = (w_cnt_sum > (CNT_W+1)'(MAX_OUTS)) ? (CNT_W)'(MAX_OUTS)
                                                         : w_cnt_sum[CNT_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ms_valid   <= 1'b0;
      r_waiting    <= 1'b0;
      r_buf_valid  <= 1'b0;
      r_cancel_cnt <= '0;
    end else begin
      if (wb_flush) begin
        r_ms_valid  <= 1'b0;
        r_waiting   <= 1'b0;
        r_buf_valid <= 1'b0;
      end else if (w_capture) begin
        r_ms_valid  <= 1'b1;
        r_waiting   <= es_mem_req & ~es_ex;
        r_buf_valid <= 1'b0;
      end else if (w_leave) begin
        r_ms_valid  <= 1'b0;
        r_waiting   <= 1'b0;
        r_buf_valid <= 1'b0;
      end else if (w_to_buf) begin
        r_buf_valid <= 1'b1;
      end
      r_cancel_cnt <= w_cnt_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc         <= '0;
      r_alu_result <= '0;
      r_load_op    <= '0;
      r_dest       <= '0;
      r_gr_we      <= 1'b0;
      r_ex         <= 1'b0;
      r_rbuf       <= '0;
    end else begin
      if (w_capture) begin
        r_pc         <= es_pc;
        r_alu_result <= es_alu_result;
        r_load_op    <= es_load_op;
        r_dest       <= es_dest;
        r_gr_we      <= es_gr_we;
        r_ex         <= es_ex;
      end
      if (w_to_buf && !wb_flush) begin
        r_rbuf <= data_rdata;
      end
    end
  end

  assign w_rd      = r_buf_valid ? r_rbuf : data_rdata;
  assign w_shifted = w_rd >> {r_alu_result[OFF_W-1:0], 3'b000};
  assign w_sb      = w_shifted[7:0];
  assign w_sh      = w_shifted[15:0];
  assign w_sw      = w_shifted[31:0];

  // load_op is one-hot {LWU,LHU,LBU,LD,LW,LH,LB}; LD/LWU only exist on a 64-bit path.
  always_comb begin
    w_ld_data = '0;
    if (r_load_op[0])      w_ld_data = DATA_W'(w_sb);
    else if (r_load_op[1]) w_ld_data = DATA_W'(w_sh);
    else if (r_load_op[2]) w_ld_data = DATA_W'(w_sw);
    else if (r_load_op[3]) w_ld_data = (DATA_W == 64) ? w_rd : '0;
    else if (r_load_op[4]) w_ld_data = DATA_W'(w_shifted[7:0]);
    else if (r_load_op[5]) w_ld_data = DATA_W'(w_shifted[15:0]);
    else if (r_load_op[6]) w_ld_data = (DATA_W == 64) ? DATA_W'(w_shifted[31:0]) : '0;
  end

  assign ms_allowin  = w_allowin;
  assign ms2ws_valid = w_out_valid;
  assign ms_pc       = r_pc;
  assign ms_dest     = r_dest;
  assign ms_ex_out   = r_ms_valid & r_ex;
  assign ms_gr_we    = r_gr_we & r_ms_valid & ~ms_ex_out;
  assign ms_result   = (|r_load_op) ? w_ld_data : r_alu_result;
  assign fwd_we      = r_ms_valid & r_gr_we;
  assign fwd_dest    = r_dest;
  assign fwd_ready   = fwd_we & w_ready_go;

  // Exceeding MAX_OUTS outstanding cancellations means the bus broke its in-flight limit.
  a_cancel_no_overflow: assert property (@(posedge clk) disable iff (reset)
                                         w_cnt_sum <= (CNT_W+1)'(MAX_OUTS));

endmodule
